// File: rtl/bram_writer_pkg.sv
// Shared defaults and writer state type for the DES-result BRAM writer.
// Included by the writer RTL and by its stream interface.
package bram_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/bram_writer_if.sv
// Valid/ready stream carrying DES result blocks into the BRAM writer.
interface bram_writer_if
  import bram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/bram_writer.sv
// Streams DEPTH result blocks into consecutive BRAM addresses, then stops and
// flags any further traffic as overflow. BRAM port outputs lag acceptance by one cycle.
module bram_writer
  import bram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  bram_writer_if.slave      in_if,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W:0]   count,
  output logic              finish,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              en_q, en_d;
  logic              finish_q, finish_d;
  logic              overflow_q, overflow_d;
  logic              ready_c;
  logic              accept_c;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      en_q       <= 1'b0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      en_q       <= en_d;
      finish_q   <= finish_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    // Gated by reset so nothing is handed over on an edge that is about to abort.
    ready_c    = reset && (state_q == ST_WRITE) && enable;
    accept_c   = in_if.in_valid && ready_c;
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    en_d       = 1'b0;
    finish_d   = finish_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (accept_c) begin
          we_d    = 1'b1;
          en_d    = 1'b1;
          addr_d  = wptr_q;
          din_d   = in_if.in_data;
          wptr_d  = wptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          if (count_q == LAST_CNT) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (in_if.in_valid) overflow_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_if.in_ready = ready_c;
  assign bram_addr      = addr_q;
  assign bram_din       = din_q;
  assign bram_we        = we_q;
  assign bram_en        = en_q;
  assign count          = count_q;
  assign finish         = finish_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_bram_writer.sv
// Randomized bench for bram_writer: a word-count model predicts ready and each
// BRAM write, covering continuous, gapped, paused, overflow and aborted runs.
module tb_bram_writer;
  import bram_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_en;
  logic          bram_we;
  logic [AW:0]   count;
  logic          finish;
  logic          overflow;

  bram_writer_if #(.DATA_W(DW)) s_if ();

  bram_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_if     (s_if),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .count     (count),
    .finish    (finish),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  // Model: armed once enable is seen out of reset; m_count words accepted so far.
  bit            m_armed = 1'b0;
  int            m_count = 0;
  bit            m_we    = 1'b0;
  bit            m_ovf   = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_din   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    bit exp_ready;
    bit acc;
    bit done_before;
    @(negedge clock);
    exp_ready   = reset && m_armed && (m_count < DEPTH) && enable;
    check("in_ready", 64'(s_if.in_ready), 64'(exp_ready));
    acc         = s_if.in_valid && exp_ready;
    done_before = m_armed && (m_count == DEPTH);
    @(posedge clock);
    if (!reset) begin
      m_armed = 1'b0;
      m_count = 0;
      m_we    = 1'b0;
      m_ovf   = 1'b0;
      m_addr  = '0;
      m_din   = '0;
    end else begin
      m_we = acc;
      if (acc) begin
        m_addr = AW'(m_count);
        m_din  = s_if.in_data;
        m_count++;
      end
      if (done_before && s_if.in_valid) m_ovf = 1'b1;
      if (enable) m_armed = 1'b1;
    end
    #1;
    check("bram_we",   64'(bram_we),   64'(m_we));
    check("bram_en",   64'(bram_en),   64'(m_we));
    check("bram_addr", 64'(bram_addr), 64'(m_addr));
    check("bram_din",  bram_din,       m_din);
    check("count",     64'(count),     64'(m_count));
    check("finish",    64'(finish),    64'(m_count == DEPTH));
    check("overflow",  64'(overflow),  64'(m_ovf));
    if (bram_we) begin
      writes_seen++;
      $display("wr addr=%0d din=%h count=%0d finish=%0b", bram_addr, bram_din, count, finish);
    end
  endtask

  // duty: % of cycles with in_valid; pause_at/rst_at: word count triggering the event (-1 = none).
  task automatic run(input int duty, input int pause_at, input int rst_at, input bit seq);
    int cyc    = 0;
    int paused = 0;
    bit did_pause = 1'b0;
    bit did_rst   = 1'b0;
    writes_seen = 0;
    reset  = 1'b1;
    enable = 1'b1;
    while (m_count < DEPTH && cyc < 20000) begin
      s_if.in_valid = ($urandom_range(99) < duty);
      s_if.in_data  = seq ? 64'(m_count) : {$urandom(), $urandom()};
      enable = 1'b1;
      reset  = 1'b1;
      if (pause_at >= 0 && !did_pause && m_count == pause_at) begin
        enable = 1'b0;
        paused++;
        if (paused == 5) did_pause = 1'b1;
      end
      if (rst_at >= 0 && !did_rst && m_count == rst_at) begin
        reset   = 1'b0;
        did_rst = 1'b1;
      end
      cycle();
      cyc++;
    end
    reset = 1'b1;
    s_if.in_valid = 1'b0;
    cycle();
    check("count_final", 64'(count), 64'(DEPTH));
    check("writes_total", 64'(writes_seen), 64'((rst_at >= 0) ? rst_at + DEPTH : DEPTH));
  endtask

  initial begin
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    repeat (2) cycle();

    // Continuous stream of data = index.
    run(100, -1, -1, 1'b1);

    // Traffic after finish must only raise overflow.
    s_if.in_valid = 1'b1;
    repeat (3) cycle();
    s_if.in_valid = 1'b0;
    repeat (3) cycle();
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Gapped stream with a 5-cycle enable pause after 100 words.
    reset = 1'b0;
    cycle();
    run(50, 100, -1, 1'b0);

    // Gapped stream aborted by reset after 500 words, then restarted from 0.
    reset = 1'b0;
    cycle();
    run(50, -1, 500, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_writer.md
BRAM_WRITER -- requirements
Module: bram_writer

Interface
REQ-001 Parameter DATA_W, 64, width of one DES result block written per BRAM word.
REQ-002 Parameter ADDR_W, 10, BRAM address width.
REQ-003 Parameter DEPTH, 1024, number of words written before finish; DEPTH <= 2**ADDR_W.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  arms the writer and permits acceptance while high.
REQ-007 in_data  input  DATA_W  result block from the DES core.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  writer accepts in_data this cycle.
REQ-010 bram_addr  output  ADDR_W  BRAM port write address.
REQ-011 bram_din  output  DATA_W  BRAM port write data.
REQ-012 bram_en  output  1  BRAM port enable.
REQ-013 bram_we  output  1  BRAM port write enable.
REQ-014 count  output  ADDR_W+1  number of words written so far, 0..DEPTH.
REQ-015 finish  output  1  sticky; all DEPTH words written.
REQ-016 overflow  output  1  sticky; in_valid was seen after finish.

Function
REQ-017 States: IDLE, WRITE, DONE. All outputs are registered.
REQ-018 IDLE -> WRITE on a cycle with enable=1; there are no other exits from IDLE.
REQ-019 in_ready = (state==WRITE) && enable. It is combinational from state and enable only, and never depends on in_valid.
REQ-020 A beat is accepted on any edge where in_valid && in_ready.
REQ-021 On an accepted beat the writer drives bram_we=1, bram_en=1, bram_din=in_data and bram_addr=wptr in the next cycle (latency 1). The write pointer wptr and count then increment by 1.
REQ-022 bram_we and bram_en are 0 in every cycle that does not follow an accepted beat. bram_addr and bram_din hold their last values.
REQ-023 Addresses are written strictly in order 0,1,...,DEPTH-1, with no gaps and no wrap-around.
REQ-024 On the edge that accepts beat number DEPTH, state moves to DONE. In the next cycle bram_we=1 for address DEPTH-1, finish=1 and count=DEPTH.
REQ-025 In DONE, in_ready=0 and no further writes occur. finish holds 1 until reset.
REQ-026 Any cycle in DONE with in_valid=1 sets overflow=1, which holds until reset.
REQ-027 enable=0 during WRITE pauses acceptance. State, wptr and count are held, and writing resumes at the next address when enable returns to 1.
REQ-028 If in_valid toggles low mid-stream, nothing is written and the address holds; no beat is dropped or duplicated.

Reset
REQ-029 When reset=0 at a rising edge, the following take these values: state=IDLE, wptr=0, count=0, bram_addr=0, bram_din=0, bram_en=0, bram_we=0, finish=0, overflow=0.
REQ-030 Reset during WRITE or DONE aborts immediately, and the BRAM write scheduled for the following cycle is suppressed.
REQ-031 in_ready=0 while reset=0.

Structure
REQ-032 The shared package bram_pkg holds DATA_W, ADDR_W and DEPTH defaults plus the writer state enum.
REQ-033 Single module with no sub-module; the BRAM itself is instantiated outside this block.

Verification
REQ-034 Reset, then enable=1 with continuous in_valid, data=i for i=0..1023 -> bram_we for 1024 consecutive cycles at addr i with din i; finish=1 and count=1024 in the cycle of the last write.
REQ-035 Random in_valid gaps at 50% duty -> writes remain in strict address order with no duplicates; the total is exactly 1024 words.
REQ-036 enable dropped for 5 cycles after 100 beats -> in_ready=0 and no writes for those cycles; the next write goes to addr 100.
REQ-037 After finish, drive in_valid=1 for 3 cycles -> no bram_we, in_ready=0, overflow=1, which remains set.
REQ-038 Assert reset for 1 cycle on the edge after beat 500 is accepted -> no write at addr 500; all outputs return to their reset values; the next run restarts at addr 0.
